// File: rtl/multicycle_ctrl_fsm_pkg.sv
// Shared encodings for the multicycle RV32I control FSM: opcodes, state codes,
// datapath select encodings and the DECODE dispatch function.
package multicycle_ctrl_fsm_pkg;

  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_R      = 7'b0110011;
  localparam logic [6:0] OP_I      = 7'b0010011;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_JAL    = 7'b1101111;
  localparam logic [6:0] OP_JALR   = 7'b1100111;
  localparam logic [6:0] OP_LUI    = 7'b0110111;
  localparam logic [6:0] OP_AUIPC  = 7'b0010111;

  typedef enum logic [3:0] {
    S_FETCH     = 4'd0,
    S_DECODE    = 4'd1,
    S_MEMADR    = 4'd2,
    S_MEMREAD   = 4'd3,
    S_MEMWB     = 4'd4,
    S_MEMWRITE  = 4'd5,
    S_EXEC_R    = 4'd6,
    S_EXEC_I    = 4'd7,
    S_ALUWB     = 4'd8,
    S_BRANCH    = 4'd9,
    S_JAL       = 4'd10,
    S_JALR      = 4'd11,
    S_JALR_LINK = 4'd12,
    S_LUI       = 4'd13,
    S_AUIPC     = 4'd14
  } state_t;

  typedef enum logic [1:0] {
    SRC_A_PC     = 2'b00,
    SRC_A_OLD_PC = 2'b01,
    SRC_A_RS1    = 2'b10,
    SRC_A_ZERO   = 2'b11
  } alu_src_a_t;

  typedef enum logic [1:0] {
    SRC_B_RS2  = 2'b00,
    SRC_B_IMM  = 2'b01,
    SRC_B_FOUR = 2'b10
  } alu_src_b_t;

  typedef enum logic [1:0] {
    ALU_ADD   = 2'b00,
    ALU_SUB   = 2'b01,
    ALU_FUNCT = 2'b10
  } alu_op_t;

  typedef enum logic [1:0] {
    RES_ALU_REG    = 2'b00,
    RES_MEM_DATA   = 2'b01,
    RES_ALU_DIRECT = 2'b10
  } result_src_t;

  // State entered after DECODE; S_FETCH marks an unknown opcode.
  function automatic state_t decode_target(input logic [6:0] opcode);
    case (opcode)
      OP_LOAD, OP_STORE: decode_target = S_MEMADR;
      OP_R:              decode_target = S_EXEC_R;
      OP_I:              decode_target = S_EXEC_I;
      OP_BRANCH:         decode_target = S_BRANCH;
      OP_JAL:            decode_target = S_JAL;
      OP_JALR:           decode_target = S_JALR;
      OP_LUI:            decode_target = S_LUI;
      OP_AUIPC:          decode_target = S_AUIPC;
      default:           decode_target = S_FETCH;
    endcase
  endfunction

endpackage

// File: rtl/multicycle_ctrl_fsm.sv
// Main control FSM of the multicycle RV32I core.
//
// state       | meaning
// ------------+----------------------------------------------------------
// FETCH       | read instr at PC, PC <= PC+4 on memory ready
// DECODE      | dispatch on opcode, alu_result <= old_pc+imm (branch target)
// MEMADR      | alu_result <= rs1+imm (load/store address)
// MEMREAD     | read at alu_result, capture mem_data on ready
// MEMWB       | rd <= mem_data
// MEMWRITE    | write at alu_result, retire on ready
// EXEC_R      | alu_result <= rs1 op rs2
// EXEC_I      | alu_result <= rs1 op imm
// ALUWB       | rd <= alu_result
// BRANCH      | compare rs1/rs2, PC <= target if taken
// JAL         | PC <= target, alu_result <= old_pc+4 (link)
// JALR        | alu_result <= rs1+imm (target)
// JALR_LINK   | PC <= target, alu_result <= old_pc+4 (link)
// LUI         | alu_result <= 0+imm
// AUIPC       | alu_result <= old_pc+imm
module multicycle_ctrl_fsm
  import multicycle_ctrl_fsm_pkg::*;
#(
  parameter int OPCODE_W = 7
) (
  input  logic                clk,
  input  logic                rst,
  input  logic [OPCODE_W-1:0] i_opcode,
  input  logic                i_mem_ready,
  input  logic                i_branch_taken,
  output logic                o_mem_req,
  output logic                o_mem_we,
  output logic                o_addr_src,
  output logic                o_instr_we,
  output logic                o_old_pc_we,
  output logic                o_mem_data_we,
  output logic                o_alu_result_we,
  output logic                o_pc_write,
  output logic                o_reg_write,
  output logic [1:0]          o_alu_src_a,
  output logic [1:0]          o_alu_src_b,
  output logic [1:0]          o_alu_op,
  output logic [1:0]          o_result_src,
  output logic                o_retire,
  output logic                o_illegal
);

  state_t      state_q, state_d;
  alu_src_a_t  src_a;
  alu_src_b_t  src_b;
  alu_op_t     alu_op;
  result_src_t result_src;

  // State register; reset always lands in FETCH, abandoning any pending request.
  always_ff @(posedge clk) begin
    if (rst) state_q <= S_FETCH;
    else     state_q <= state_d;
  end

  // Next state and per-state datapath controls; reset masks everything to 0.
  always_comb begin
    state_d         = state_q;
    o_mem_req       = 1'b0;
    o_mem_we        = 1'b0;
    o_addr_src      = 1'b0;
    o_instr_we      = 1'b0;
    o_old_pc_we     = 1'b0;
    o_mem_data_we   = 1'b0;
    o_alu_result_we = 1'b0;
    o_pc_write      = 1'b0;
    o_reg_write     = 1'b0;
    o_retire        = 1'b0;
    o_illegal       = 1'b0;
    src_a           = SRC_A_PC;
    src_b           = SRC_B_RS2;
    alu_op          = ALU_ADD;
    result_src      = RES_ALU_REG;

    case (state_q)
      S_FETCH: begin
        o_mem_req  = 1'b1;
        src_b      = SRC_B_FOUR;
        result_src = RES_ALU_DIRECT;
        if (i_mem_ready) begin
          o_instr_we  = 1'b1;
          o_old_pc_we = 1'b1;
          o_pc_write  = 1'b1;
          state_d     = S_DECODE;
        end
      end
      S_DECODE: begin
        src_a           = SRC_A_OLD_PC;
        src_b           = SRC_B_IMM;
        o_alu_result_we = 1'b1;
        state_d         = decode_target(i_opcode);
        o_illegal       = (decode_target(i_opcode) == S_FETCH);
      end
      S_MEMADR: begin
        src_a           = SRC_A_RS1;
        src_b           = SRC_B_IMM;
        o_alu_result_we = 1'b1;
        state_d         = (i_opcode == OP_LOAD) ? S_MEMREAD : S_MEMWRITE;
      end
      S_MEMREAD: begin
        o_mem_req  = 1'b1;
        o_addr_src = 1'b1;
        if (i_mem_ready) begin
          o_mem_data_we = 1'b1;
          state_d       = S_MEMWB;
        end
      end
      S_MEMWB: begin
        result_src  = RES_MEM_DATA;
        o_reg_write = 1'b1;
        o_retire    = 1'b1;
        state_d     = S_FETCH;
      end
      S_MEMWRITE: begin
        o_mem_req  = 1'b1;
        o_mem_we   = 1'b1;
        o_addr_src = 1'b1;
        if (i_mem_ready) begin
          o_retire = 1'b1;
          state_d  = S_FETCH;
        end
      end
      S_EXEC_R, S_EXEC_I: begin
        src_a           = SRC_A_RS1;
        src_b           = (state_q == S_EXEC_R) ? SRC_B_RS2 : SRC_B_IMM;
        alu_op          = ALU_FUNCT;
        o_alu_result_we = 1'b1;
        state_d         = S_ALUWB;
      end
      S_ALUWB: begin
        o_reg_write = 1'b1;
        o_retire    = 1'b1;
        state_d     = S_FETCH;
      end
      S_BRANCH: begin
        src_a      = SRC_A_RS1;
        alu_op     = ALU_SUB;
        o_pc_write = i_branch_taken;
        o_retire   = 1'b1;
        state_d    = S_FETCH;
      end
      // alu_result still holds the target while the ALU forms the link value.
      S_JAL, S_JALR_LINK: begin
        src_a           = SRC_A_OLD_PC;
        src_b           = SRC_B_FOUR;
        o_alu_result_we = 1'b1;
        o_pc_write      = 1'b1;
        state_d         = S_ALUWB;
      end
      S_JALR: begin
        src_a           = SRC_A_RS1;
        src_b           = SRC_B_IMM;
        o_alu_result_we = 1'b1;
        state_d         = S_JALR_LINK;
      end
      S_LUI, S_AUIPC: begin
        src_a           = (state_q == S_LUI) ? SRC_A_ZERO : SRC_A_OLD_PC;
        src_b           = SRC_B_IMM;
        o_alu_result_we = 1'b1;
        state_d         = S_ALUWB;
      end
      default: state_d = S_FETCH;
    endcase

    if (rst) begin
      o_mem_req       = 1'b0;
      o_mem_we        = 1'b0;
      o_addr_src      = 1'b0;
      o_instr_we      = 1'b0;
      o_old_pc_we     = 1'b0;
      o_mem_data_we   = 1'b0;
      o_alu_result_we = 1'b0;
      o_pc_write      = 1'b0;
      o_reg_write     = 1'b0;
      o_retire        = 1'b0;
      o_illegal       = 1'b0;
      src_a           = SRC_A_PC;
      src_b           = SRC_B_RS2;
      alu_op          = ALU_ADD;
      result_src      = RES_ALU_REG;
    end
  end

  assign o_alu_src_a  = src_a;
  assign o_alu_src_b  = src_b;
  assign o_alu_op     = alu_op;
  assign o_result_src = result_src;

endmodule

// File: tb/tb_multicycle_ctrl_fsm.sv
// Directed bench for multicycle_ctrl_fsm: per-cycle expected state and control word.
module tb_multicycle_ctrl_fsm;

  logic       clk = 1'b0;
  logic       rst;
  logic [6:0] opcode;
  logic       mem_ready;
  logic       branch_taken;
  logic       mem_req, mem_we, addr_src, instr_we, old_pc_we, mem_data_we;
  logic       alu_result_we, pc_write, reg_write, retire, illegal;
  logic [1:0] alu_src_a, alu_src_b, alu_op, result_src;

  int n_cmp = 0;
  int n_bad = 0;

  multicycle_ctrl_fsm #(.OPCODE_W(7)) dut (
    .clk             (clk),
    .rst             (rst),
    .i_opcode        (opcode),
    .i_mem_ready     (mem_ready),
    .i_branch_taken  (branch_taken),
    .o_mem_req       (mem_req),
    .o_mem_we        (mem_we),
    .o_addr_src      (addr_src),
    .o_instr_we      (instr_we),
    .o_old_pc_we     (old_pc_we),
    .o_mem_data_we   (mem_data_we),
    .o_alu_result_we (alu_result_we),
    .o_pc_write      (pc_write),
    .o_reg_write     (reg_write),
    .o_alu_src_a     (alu_src_a),
    .o_alu_src_b     (alu_src_b),
    .o_alu_op        (alu_op),
    .o_result_src    (result_src),
    .o_retire        (retire),
    .o_illegal       (illegal)
  );

  always #5 clk = ~clk;

  localparam logic [3:0] ST_FETCH = 4'd0, ST_DECODE = 4'd1, ST_MEMADR = 4'd2,
    ST_MEMREAD = 4'd3, ST_MEMWB = 4'd4, ST_MEMWRITE = 4'd5, ST_EXEC_R = 4'd6,
    ST_EXEC_I = 4'd7, ST_ALUWB = 4'd8, ST_BRANCH = 4'd9, ST_JAL = 4'd10,
    ST_JALR = 4'd11, ST_JALR_LINK = 4'd12, ST_LUI = 4'd13, ST_AUIPC = 4'd14;

  // Control word layout:
  // {req, we, addr_src, instr_we, old_pc_we, mem_data_we, alu_result_we,
  //  pc_write, reg_write, src_a, src_b, alu_op, result_src, retire, illegal}
  function automatic logic [18:0] cw(
    input logic req, we, asrc, iwe, opwe, mdwe, arwe, pcw, rw,
    input logic [1:0] a, b, op, rs,
    input logic ret, ill);
    return {req, we, asrc, iwe, opwe, mdwe, arwe, pcw, rw, a, b, op, rs, ret, ill};
  endfunction

  logic [18:0] observed;
  assign observed = {mem_req, mem_we, addr_src, instr_we, old_pc_we, mem_data_we,
                     alu_result_we, pc_write, reg_write, alu_src_a, alu_src_b,
                     alu_op, result_src, retire, illegal};

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // Drive inputs for one cycle, check state and control word, then clock.
  task automatic cyc(input string tag, input logic r, input logic rdy, input logic tk,
                     input logic [3:0] exp_state, input logic [18:0] exp_cw);
    rst = r;
    mem_ready = rdy;
    branch_taken = tk;
    #1;
    check({tag, ".state"}, 32'(dut.state_q), 32'(exp_state));
    check({tag, ".ctrl"}, 32'(observed), 32'(exp_cw));
    @(posedge clk);
    #1;
  endtask

  logic [18:0] ZERO, FETCH_WAIT, FETCH_GO, DEC, DEC_ILL, MEMADR, MEMRD_WAIT,
               MEMRD_GO, MEMWB, MEMWR_WAIT, MEMWR_GO, EXEC_R, EXEC_I, ALUWB,
               BR_NT, BR_T, LINK, JALR, LUI, AUIPC;

  initial begin
    ZERO       = '0;
    FETCH_WAIT = cw(1,0,0,0,0,0,0,0,0, 2'd0,2'd2,2'd0,2'd2, 0,0);
    FETCH_GO   = cw(1,0,0,1,1,0,0,1,0, 2'd0,2'd2,2'd0,2'd2, 0,0);
    DEC        = cw(0,0,0,0,0,0,1,0,0, 2'd1,2'd1,2'd0,2'd0, 0,0);
    DEC_ILL    = cw(0,0,0,0,0,0,1,0,0, 2'd1,2'd1,2'd0,2'd0, 0,1);
    MEMADR     = cw(0,0,0,0,0,0,1,0,0, 2'd2,2'd1,2'd0,2'd0, 0,0);
    MEMRD_WAIT = cw(1,0,1,0,0,0,0,0,0, 2'd0,2'd0,2'd0,2'd0, 0,0);
    MEMRD_GO   = cw(1,0,1,0,0,1,0,0,0, 2'd0,2'd0,2'd0,2'd0, 0,0);
    MEMWB      = cw(0,0,0,0,0,0,0,0,1, 2'd0,2'd0,2'd0,2'd1, 1,0);
    MEMWR_WAIT = cw(1,1,1,0,0,0,0,0,0, 2'd0,2'd0,2'd0,2'd0, 0,0);
    MEMWR_GO   = cw(1,1,1,0,0,0,0,0,0, 2'd0,2'd0,2'd0,2'd0, 1,0);
    EXEC_R     = cw(0,0,0,0,0,0,1,0,0, 2'd2,2'd0,2'd2,2'd0, 0,0);
    EXEC_I     = cw(0,0,0,0,0,0,1,0,0, 2'd2,2'd1,2'd2,2'd0, 0,0);
    ALUWB      = cw(0,0,0,0,0,0,0,0,1, 2'd0,2'd0,2'd0,2'd0, 1,0);
    BR_NT      = cw(0,0,0,0,0,0,0,0,0, 2'd2,2'd0,2'd1,2'd0, 1,0);
    BR_T       = cw(0,0,0,0,0,0,0,1,0, 2'd2,2'd0,2'd1,2'd0, 1,0);
    LINK       = cw(0,0,0,0,0,0,1,1,0, 2'd1,2'd2,2'd0,2'd0, 0,0);
    JALR       = cw(0,0,0,0,0,0,1,0,0, 2'd2,2'd1,2'd0,2'd0, 0,0);
    LUI        = cw(0,0,0,0,0,0,1,0,0, 2'd3,2'd1,2'd0,2'd0, 0,0);
    AUIPC      = cw(0,0,0,0,0,0,1,0,0, 2'd1,2'd1,2'd0,2'd0, 0,0);

    rst = 1'b1;
    mem_ready = 1'b1;
    branch_taken = 1'b1;
    opcode = 7'b0110011;
    @(posedge clk);
    #1;
    // Reset with ready/taken high: all outputs still forced low.
    cyc("rst", 1, 1, 1, ST_FETCH, ZERO);

    // R-type, no stalls.
    cyc("r.fetch",  0, 1, 0, ST_FETCH,  FETCH_GO);
    cyc("r.decode", 0, 0, 0, ST_DECODE, DEC);
    cyc("r.exec",   0, 0, 0, ST_EXEC_R, EXEC_R);
    cyc("r.wb",     0, 0, 0, ST_ALUWB,  ALUWB);

    // Load: 3 FETCH stalls, 2 MEMREAD stalls -> 10 cycles.
    opcode = 7'b0000011;
    for (int i = 0; i < 3; i++) cyc("ld.fetch_wait", 0, 0, 0, ST_FETCH, FETCH_WAIT);
    cyc("ld.fetch",  0, 1, 0, ST_FETCH,  FETCH_GO);
    cyc("ld.decode", 0, 0, 0, ST_DECODE, DEC);
    cyc("ld.memadr", 0, 0, 0, ST_MEMADR, MEMADR);
    for (int i = 0; i < 2; i++) cyc("ld.rd_wait", 0, 0, 0, ST_MEMREAD, MEMRD_WAIT);
    cyc("ld.rd",     0, 1, 0, ST_MEMREAD, MEMRD_GO);
    cyc("ld.wb",     0, 0, 0, ST_MEMWB,   MEMWB);

    // Store with ready held high everywhere: it is ignored where no request is out.
    opcode = 7'b0100011;
    cyc("st.fetch",  0, 1, 0, ST_FETCH,    FETCH_GO);
    cyc("st.decode", 0, 1, 0, ST_DECODE,   DEC);
    cyc("st.memadr", 0, 1, 0, ST_MEMADR,   MEMADR);
    cyc("st.write",  0, 1, 0, ST_MEMWRITE, MEMWR_GO);

    // Store with one write stall.
    cyc("st2.fetch",  0, 1, 0, ST_FETCH,    FETCH_GO);
    cyc("st2.decode", 0, 0, 0, ST_DECODE,   DEC);
    cyc("st2.memadr", 0, 0, 0, ST_MEMADR,   MEMADR);
    cyc("st2.wait",   0, 0, 0, ST_MEMWRITE, MEMWR_WAIT);
    cyc("st2.write",  0, 1, 0, ST_MEMWRITE, MEMWR_GO);

    // Branch not taken, then taken (taken high in DECODE must not matter).
    opcode = 7'b1100011;
    cyc("bnt.fetch",  0, 1, 0, ST_FETCH,  FETCH_GO);
    cyc("bnt.decode", 0, 0, 0, ST_DECODE, DEC);
    cyc("bnt.branch", 0, 0, 0, ST_BRANCH, BR_NT);
    cyc("bt.fetch",   0, 1, 1, ST_FETCH,  FETCH_GO);
    cyc("bt.decode",  0, 0, 1, ST_DECODE, DEC);
    cyc("bt.branch",  0, 0, 1, ST_BRANCH, BR_T);

    // JALR: 5 cycles, PC written only in JALR_LINK.
    opcode = 7'b1100111;
    cyc("jalr.fetch",  0, 1, 0, ST_FETCH,     FETCH_GO);
    cyc("jalr.decode", 0, 0, 0, ST_DECODE,    DEC);
    cyc("jalr.target", 0, 0, 0, ST_JALR,      JALR);
    cyc("jalr.link",   0, 0, 0, ST_JALR_LINK, LINK);
    cyc("jalr.wb",     0, 0, 0, ST_ALUWB,     ALUWB);

    // JAL, EXEC_I, LUI, AUIPC dispatch.
    opcode = 7'b1101111;
    cyc("jal.fetch",  0, 1, 0, ST_FETCH,  FETCH_GO);
    cyc("jal.decode", 0, 0, 0, ST_DECODE, DEC);
    cyc("jal.link",   0, 0, 0, ST_JAL,    LINK);
    cyc("jal.wb",     0, 0, 0, ST_ALUWB,  ALUWB);
    opcode = 7'b0010011;
    cyc("i.fetch",  0, 1, 0, ST_FETCH,  FETCH_GO);
    cyc("i.decode", 0, 0, 0, ST_DECODE, DEC);
    cyc("i.exec",   0, 0, 0, ST_EXEC_I, EXEC_I);
    cyc("i.wb",     0, 0, 0, ST_ALUWB,  ALUWB);
    opcode = 7'b0110111;
    cyc("lui.fetch",  0, 1, 0, ST_FETCH,  FETCH_GO);
    cyc("lui.decode", 0, 0, 0, ST_DECODE, DEC);
    cyc("lui.exec",   0, 0, 0, ST_LUI,    LUI);
    cyc("lui.wb",     0, 0, 0, ST_ALUWB,  ALUWB);
    opcode = 7'b0010111;
    cyc("auipc.fetch",  0, 1, 0, ST_FETCH,  FETCH_GO);
    cyc("auipc.decode", 0, 0, 0, ST_DECODE, DEC);
    cyc("auipc.exec",   0, 0, 0, ST_AUIPC,  AUIPC);
    cyc("auipc.wb",     0, 0, 0, ST_ALUWB,  ALUWB);

    // Illegal opcode: one-cycle pulse, back to FETCH, no retire.
    opcode = 7'b1111111;
    cyc("ill.fetch",  0, 1, 0, ST_FETCH,  FETCH_GO);
    cyc("ill.decode", 0, 0, 0, ST_DECODE, DEC_ILL);
    cyc("ill.after",  0, 0, 0, ST_FETCH,  FETCH_WAIT);

    // Reset during a MEMREAD stall abandons the request.
    opcode = 7'b0000011;
    cyc("rs.fetch",  0, 1, 0, ST_FETCH,   FETCH_GO);
    cyc("rs.decode", 0, 0, 0, ST_DECODE,  DEC);
    cyc("rs.memadr", 0, 0, 0, ST_MEMADR,  MEMADR);
    cyc("rs.wait",   0, 0, 0, ST_MEMREAD, MEMRD_WAIT);
    cyc("rs.reset",  1, 1, 0, ST_MEMREAD, ZERO);
    cyc("rs.after",  0, 0, 0, ST_FETCH,   FETCH_WAIT);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/multicycle_ctrl_fsm.md
Name: multicycle_ctrl_fsm

Overview:
- Main control FSM for the multicycle RV32I core.
- Sequences the shared ALU, the memory port and the nonarchitectural write-enable registers: instr, old_pc, mem_data and alu_result.
- Decodes the opcode and drives mux selects and register enables each cycle.
- Stalls on a valid/ready memory handshake. Sits between the instruction register and the datapath.

Parameters:
- OPCODE_W, 7, opcode field width.

Ports:
- clk  in  1  clock, rising edge.
- rst  in  1  synchronous, active-high reset.
- i_opcode  in  7  instr[6:0] from instruction register.
- i_mem_ready  in  1  memory completes current request this cycle.
- i_branch_taken  in  1  branch condition from ALU flags, valid in BRANCH.
- o_mem_req  out  1  memory request valid.
- o_mem_we  out  1  request is a write.
- o_addr_src  out  1  memory address: 0 PC, 1 alu_result register.
- o_instr_we  out  1  instr register enable.
- o_old_pc_we  out  1  old_pc register enable.
- o_mem_data_we  out  1  mem_data register enable.
- o_alu_result_we  out  1  alu_result register enable.
- o_pc_write  out  1  PC register enable.
- o_reg_write  out  1  register-file write.
- o_alu_src_a  out  2  00 PC, 01 old_pc, 10 rs1 (reg A), 11 zero.
- o_alu_src_b  out  2  00 rs2 (reg B), 01 imm, 10 const 4.
- o_alu_op  out  2  00 add, 01 sub/compare, 10 funct-decoded.
- o_result_src  out  2  00 alu_result reg, 01 mem_data reg, 10 ALU direct.
- o_retire  out  1  one-cycle pulse on final cycle of each instruction.
- o_illegal  out  1  one-cycle pulse on unknown opcode.

Behaviour:
- Single state register; outputs are combinational from state, i_mem_ready and i_branch_taken.
- Reset:
  - rst=1 at edge -> state=FETCH.
  - While rst=1, every enable/req/pulse output is forced 0; selects are 0.
- Defaults (every state): all enables 0; selects 00.
- FETCH:
  - o_mem_req=1, addr_src=0.
  - ALU computes PC+4: a=00, b=10, op=00, result_src=10.
  - When i_mem_ready=1: instr_we=1, old_pc_we=1, pc_write=1, next DECODE.
  - Otherwise hold in FETCH with o_mem_req held 1.
- DECODE:
  - Computes old_pc+imm: a=01, b=01, alu_result_we=1.
  - Next state by opcode:
    - 0000011 / 0100011 -> MEMADR
    - 0110011 -> EXEC_R
    - 0010011 -> EXEC_I
    - 1100011 -> BRANCH
    - 1101111 -> JAL
    - 1100111 -> JALR
    - 0110111 -> LUI
    - 0010111 -> AUIPC
    - other -> FETCH with o_illegal=1 (no retire).
- MEMADR: a=10, b=01, add, alu_result_we=1. Next MEMREAD if opcode is a load, else MEMWRITE.
- MEMREAD: mem_req=1, addr_src=1. On ready: mem_data_we=1, next MEMWB; else hold.
- MEMWB: result_src=01, reg_write=1, retire=1, next FETCH.
- MEMWRITE: mem_req=1, mem_we=1, addr_src=1. On ready: retire=1, next FETCH; else hold.
- EXEC_R: a=10, b=00, op=10, alu_result_we=1, next ALUWB.
- EXEC_I: a=10, b=01, op=10, alu_result_we=1, next ALUWB.
- ALUWB: result_src=00, reg_write=1, retire=1, next FETCH.
- BRANCH:
  - a=10, b=00, op=01, result_src=00 (target from DECODE).
  - pc_write=i_branch_taken, retire=1, next FETCH.
- JAL:
  - a=01, b=10, add, alu_result_we=1 (link value).
  - result_src=00, pc_write=1, next ALUWB.
- JALR: a=10, b=01, add, alu_result_we=1 (target), next JALR_LINK.
- JALR_LINK:
  - a=01, b=10, add, alu_result_we=1.
  - result_src=00, pc_write=1, next ALUWB.
- LUI: a=11, b=01, add, alu_result_we=1, next ALUWB.
- AUIPC: a=01, b=01, add, alu_result_we=1, next ALUWB.
- Boundary rules:
  - i_mem_ready is ignored when o_mem_req=0.
  - i_mem_ready held high produces no double-enables: each memory state consumes exactly one ready.
  - Reset mid-stall abandons the request; o_mem_req drops in the reset cycle.
  - Illegal opcode advances nothing and does not write the PC.

Decomposition:
- Shared package holds:
  - opcode constants
  - state enum typedef
  - alu_src_a/b, alu_op and result_src encodings as typedef enums
- No sub-module. Optional: a single-cycle combinational opcode-class decoder function in the package.

Test Plan:
- Reset then opcode 0110011, ready=1 in FETCH:
  - Required states: FETCH, DECODE, EXEC_R, ALUWB, FETCH.
  - reg_write=1 only in ALUWB; retire pulses once.
- Load 0000011, ready held 0 for 3 FETCH cycles and 2 MEMREAD cycles:
  - o_mem_req stays 1 throughout both stalls.
  - instr_we and mem_data_we each pulse exactly once, on the ready cycle.
  - Total latency is 5 + 5 = 10 cycles.
- Store 0100011:
  - mem_we=1 and addr_src=1 in MEMWRITE.
  - reg_write never asserted; 4 cycles with no stalls.
- Branch 1100011 with taken=0 then taken=1:
  - pc_write is 0 then 1 in BRANCH.
  - Both return to FETCH after 3 cycles.
- JALR 1100111:
  - pc_write only in JALR_LINK with result_src=00.
  - ALUWB writes the link value; 5 cycles total.
- Opcode 1111111 in DECODE: o_illegal=1 for one cycle, FETCH next, no retire. Then rst=1 during a MEMREAD stall: all outputs 0, FETCH after the reset cycle.
